slave_port: RTL and testbench

//  Responder end of the serial system bus: one bit per clock, driven by master_port via the arbiter.
//  - Deserialises address, plus write data for writes, from wr_bus.
//  - Performs one access on a local memory-side interface.
//  - For reads, serialises the returned data back on rd_bus.
//  - One instance per slave (s1..s3) behind the arbiter's per-slave signal group.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/bus_shift_reg.sv | 29 ++
 rtl/slave_port.sv | 174 +++++++++++++++++
 tb/tb_slave_port.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: transfer modes,
// default widths and the slave-side state encoding.
package bus_pkg;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        RD_REQ,
        RD_WAIT,
        RDATA
    } slave_state_t;

endpackage

// File: rtl/bus_shift_reg.sv
// Parallel-load / serial-in shift register, LSB first.
// Ports: clk, rstn, load/load_data (parallel load, wins over shift),
//        shift_en/serial_in (new bit enters at MSB), q (contents).
module bus_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    // Bits enter at the MSB and move down, so after WIDTH shifts of an
    // LSB-first stream the word sits in natural order; q[0] is the
    // serial output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {serial_in, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/slave_port.sv
// Responder end of the bit-serial system bus.
// Ports: clk, rstn; master side mode/wr_bus/master_valid/master_ready,
//        rd_bus/slave_ready/slave_valid; memory side mem_addr,
//        mem_wr_data, mem_wr_en, mem_rd_en, mem_rd_data, mem_rd_valid.
module slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mode,
    input  logic                  wr_bus,
    input  logic                  master_valid,
    input  logic                  master_ready,
    output logic                  rd_bus,
    output logic                  slave_ready,
    output logic                  slave_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_valid
);

    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    slave_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mode_q, mode_nxt;
    logic             addr_shift;
    logic             wdata_shift;
    logic             rdata_load;
    logic             rdata_shift;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= MODE_READ;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mode_nxt    = mode_q;
        addr_shift  = 1'b0;
        wdata_shift = 1'b0;
        rdata_load  = 1'b0;
        rdata_shift = 1'b0;
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b0;
        slave_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (master_valid) begin
                    mode_nxt   = mode;
                    addr_shift = 1'b1;
                    cnt_nxt    = CNT_W'(1);
                    state_nxt  = ADDR;
                end
            end
            ADDR: begin
                if (!master_valid) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    addr_shift = 1'b1;
                    if (cnt == ADDR_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = (mode_q == MODE_WRITE) ? WDATA : RD_REQ;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            WDATA: begin
                if (!master_valid) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    wdata_shift = 1'b1;
                    if (cnt == DATA_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = WRITE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            WRITE: begin
                mem_wr_en = 1'b1;
                state_nxt = IDLE;
            end
            RD_REQ: begin
                // Zero-latency memories answer in the strobe cycle itself.
                mem_rd_en = 1'b1;
                if (mem_rd_valid) begin
                    rdata_load = 1'b1;
                    state_nxt  = RDATA;
                end else begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rd_valid) begin
                    rdata_load = 1'b1;
                    state_nxt  = RDATA;
                end
            end
            RDATA: begin
                slave_valid = 1'b1;
                if (master_ready) begin
                    rdata_shift = 1'b1;
                    if (cnt == DATA_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign slave_ready = (state == IDLE);
    assign rd_bus      = slave_valid & rdata_q[0];

    bus_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr (
        .clk       (clk),
        .rstn      (rstn),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (addr_shift),
        .serial_in (wr_bus),
        .q         (mem_addr)
    );

    bus_shift_reg #(.WIDTH(DATA_WIDTH)) u_wdata (
        .clk       (clk),
        .rstn      (rstn),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (wdata_shift),
        .serial_in (wr_bus),
        .q         (mem_wr_data)
    );

    bus_shift_reg #(.WIDTH(DATA_WIDTH)) u_rdata (
        .clk       (clk),
        .rstn      (rstn),
        .load      (rdata_load),
        .load_data (mem_rd_data),
        .shift_en  (rdata_shift),
        .serial_in (1'b0),
        .q         (rdata_q)
    );

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: drives the serial master side, models the
// local memory, and checks transfers against a reference memory.
module tb_slave_port;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mode = 1'b0;
    logic        wr_bus = 1'b0;
    logic        master_valid = 1'b0;
    logic        master_ready = 1'b0;
    logic        rd_bus;
    logic        slave_ready;
    logic        slave_valid;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        mem_rd_valid = 1'b0;

    int err = 0;
    int chk = 0;
    int rd_lat = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    logic [7:0] mem_store [int];
    logic [7:0] ref_mem [int];

    slave_port dut (
        .clk          (clk),
        .rstn         (rstn),
        .mode         (mode),
        .wr_bus       (wr_bus),
        .master_valid (master_valid),
        .master_ready (master_ready),
        .rd_bus       (rd_bus),
        .slave_ready  (slave_ready),
        .slave_valid  (slave_valid),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en === 1'b1) begin
            mem_store[int'(mem_addr)] = mem_wr_data;
            wr_cnt++;
        end
        if (mem_rd_en === 1'b1) rd_cnt++;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mem_rd_en === 1'b1) begin
                int a;
                a = int'(mem_addr);
                repeat (rd_lat) @(negedge clk);
                mem_rd_data  = mem_store.exists(a) ? mem_store[a] : 8'h00;
                mem_rd_valid = 1'b1;
                @(negedge clk);
                mem_rd_valid = 1'b0;
                mem_rd_data  = 8'($urandom);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_addr(input logic m, input logic [11:0] a);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            master_valid = 1'b1;
            mode = (i == 0) ? m : 1'($urandom);
            wr_bus = a[i];
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d);
        int w0;
        w0 = wr_cnt;
        send_addr(1'b1, a);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_bus = d[i];
            mode = 1'($urandom);
        end
        @(negedge clk);
        master_valid = 1'b0;
        wr_bus = 1'b0;
        chk++;
        if (mem_wr_en !== 1'b1 || mem_addr !== a || mem_wr_data !== d) begin
            err++;
            $display("FAIL write strobe: en=%b addr=%h data=%h, want en=1 addr=%h data=%h",
                     mem_wr_en, mem_addr, mem_wr_data, a, d);
        end
        chk++;
        if (slave_ready !== 1'b0) begin
            err++;
            $display("FAIL write busy: slave_ready=%b, want 0", slave_ready);
        end
        @(negedge clk);
        chk++;
        if (mem_wr_en !== 1'b0 || slave_ready !== 1'b1) begin
            err++;
            $display("FAIL write done: en=%b ready=%b, want en=0 ready=1",
                     mem_wr_en, slave_ready);
        end
        chk++;
        if (wr_cnt != w0 + 1) begin
            err++;
            $display("FAIL write count: %0d strobes, want 1", wr_cnt - w0);
        end
        ref_mem[int'(a)] = d;
    endtask

    task automatic do_read(input logic [11:0] a, input int lat, input int stall_at,
                           input int stall_len, input logic [7:0] exp);
        int waits;
        int k;
        int left;
        int r0;
        logic [7:0] got;
        r0 = rd_cnt;
        rd_lat = lat;
        master_ready = 1'b1;
        send_addr(1'b0, a);
        @(negedge clk);
        master_valid = 1'b0;
        wr_bus = 1'b0;
        chk++;
        if (mem_rd_en !== 1'b1 || mem_addr !== a || slave_valid !== 1'b0) begin
            err++;
            $display("FAIL read strobe: en=%b addr=%h sv=%b, want en=1 addr=%h sv=0",
                     mem_rd_en, mem_addr, slave_valid, a);
        end
        waits = 0;
        while (slave_valid !== 1'b1 && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        chk++;
        if (waits != lat + 1) begin
            err++;
            $display("FAIL read latency: %0d cycles, want %0d", waits, lat + 1);
        end
        if (slave_valid !== 1'b1) return;
        chk++;
        if (rd_cnt != r0 + 1) begin
            err++;
            $display("FAIL read count: %0d strobes, want 1", rd_cnt - r0);
        end
        k = 0;
        left = stall_len;
        got = 8'h00;
        while (k < 8) begin
            chk++;
            if (slave_valid !== 1'b1 || rd_bus !== exp[k]) begin
                err++;
                $display("FAIL read bit %0d: sv=%b rd_bus=%b, want sv=1 rd_bus=%b",
                         k, slave_valid, rd_bus, exp[k]);
            end
            got[k] = rd_bus;
            if (k == stall_at && left > 0) begin
                master_ready = 1'b0;
                left--;
            end else begin
                master_ready = 1'b1;
                k++;
            end
            @(negedge clk);
        end
        master_ready = 1'($urandom);
        chk++;
        if (slave_valid !== 1'b0 || rd_bus !== 1'b0 || slave_ready !== 1'b1) begin
            err++;
            $display("FAIL read end: sv=%b rd_bus=%b ready=%b, want 0 0 1",
                     slave_valid, rd_bus, slave_ready);
        end
        chk++;
        if (got !== exp) begin
            err++;
            $display("FAIL read byte %h: got %h, want %h", a, got, exp);
        end
    endtask

    task automatic test_reset();
        master_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk++;
        if (slave_ready !== 1'b1 || slave_valid !== 1'b0 || rd_bus !== 1'b0 ||
            mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 ||
            mem_addr !== 12'h000 || mem_wr_data !== 8'h00) begin
            err++;
            $display("FAIL reset: ready=%b sv=%b rd=%b we=%b re=%b addr=%h wd=%h",
                     slave_ready, slave_valid, rd_bus, mem_wr_en, mem_rd_en,
                     mem_addr, mem_wr_data);
        end
        master_valid = 1'b0;
        rstn = 1'b1;
    endtask

    task automatic test_write();
        do_write(12'hbcd, 8'hd3);
    endtask

    task automatic test_read_zero();
        mem_store[12'h0a5] = 8'h5c;
        do_read(12'h0a5, 0, 8, 0, 8'h5c);
    endtask

    task automatic test_read_stall();
        mem_store[12'h123] = 8'h81;
        do_read(12'h123, 3, 4, 2, 8'h81);
    endtask

    task automatic test_abort();
        int w0;
        int r0;
        logic [11:0] a;
        w0 = wr_cnt;
        r0 = rd_cnt;
        a = 12'hfff;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            master_valid = 1'b1;
            mode = 1'b1;
            wr_bus = a[i];
        end
        @(negedge clk);
        master_valid = 1'b0;
        @(negedge clk);
        chk++;
        if (slave_ready !== 1'b1) begin
            err++;
            $display("FAIL abort addr ready: %b, want 1", slave_ready);
        end
        send_addr(1'b1, 12'h555);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_bus = 1'b1;
        end
        @(negedge clk);
        master_valid = 1'b0;
        @(negedge clk);
        chk++;
        if (slave_ready !== 1'b1) begin
            err++;
            $display("FAIL abort data ready: %b, want 1", slave_ready);
        end
        repeat (3) @(negedge clk);
        chk++;
        if (wr_cnt != w0 || rd_cnt != r0) begin
            err++;
            $display("FAIL abort strobes: wr=%0d rd=%0d, want 0 0",
                     wr_cnt - w0, rd_cnt - r0);
        end
        do_write(12'h001, 8'hff);
        do_read(12'h001, 1, 8, 0, 8'hff);
    endtask

    task automatic test_reset_rdata();
        int waits;
        mem_store[12'h2a4] = 8'h96;
        rd_lat = 0;
        master_ready = 1'b1;
        send_addr(1'b0, 12'h2a4);
        @(negedge clk);
        master_valid = 1'b0;
        waits = 0;
        while (slave_valid !== 1'b1 && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        chk++;
        if (slave_valid !== 1'b1) begin
            err++;
            $display("FAIL rst-rdata start: sv=%b, want 1", slave_valid);
        end
        repeat (2) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk++;
        if (slave_valid !== 1'b0 || rd_bus !== 1'b0 || slave_ready !== 1'b1 ||
            mem_addr !== 12'h000) begin
            err++;
            $display("FAIL rst-rdata: sv=%b rd=%b ready=%b addr=%h, want 0 0 1 000",
                     slave_valid, rd_bus, slave_ready, mem_addr);
        end
        @(negedge clk);
        rstn = 1'b1;
        do_read(12'h2a4, 2, 8, 0, 8'h96);
    endtask

    task automatic test_back_to_back();
        do_write(12'h3c0, 8'h7e);
        do_read(12'h3c0, 0, 8, 0, 8'h7e);
    endtask

    task automatic test_random();
        logic [11:0] a;
        logic [7:0]  d;
        for (int n = 0; n < 8; n++) begin
            a = 12'($urandom);
            d = 8'($urandom);
            do_write(a, d);
            do_read(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), ref_mem[int'(a)]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_zero();
        test_read_stall();
        test_abort();
        test_reset_rdata();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
